// File: rtl/axi4lite_arbiter2_pkg.sv
// Shared AXI4-lite definitions: response codes, arbiter FSM states and default widths.
package axi4lite_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W_DEF = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi4lite_arbiter2_if.sv
// AXI4-lite channel bundle; master modport drives requests, slave modport drives responses.
interface axi4lite_if
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W = STRB_W_DEF
) ();

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4lite_arbiter2_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi4lite_arbiter2.sv
// Two-master AXI4-lite arbiter: whole transactions granted round-robin, owner channels
// routed combinationally to the slave, everything else gated to zero.
module axi4lite_arbiter2
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W = STRB_W_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi4lite_if.slave   m0,
    axi4lite_if.slave   m1,
    axi4lite_if.master  s
);

    arb_state_t state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_reg, last_next;

    logic       grant_idx;
    logic       grant_valid;
    logic [1:0] wreq;
    logic [1:0] rreq;

    // Master inputs flattened into arrays so the owner can index them
    logic              m_awvalid [2];
    logic [ADDR_W-1:0] m_awaddr  [2];
    logic              m_wvalid  [2];
    logic [DATA_W-1:0] m_wdata   [2];
    logic [STRB_W-1:0] m_wstrb   [2];
    logic              m_bready  [2];
    logic              m_arvalid [2];
    logic [ADDR_W-1:0] m_araddr  [2];
    logic              m_rready  [2];

    logic              route_awready [2];
    logic              route_wready  [2];
    logic              route_bvalid  [2];
    logic [1:0]        route_bresp   [2];
    logic              route_arready [2];
    logic              route_rvalid  [2];
    logic [DATA_W-1:0] route_rdata   [2];
    logic [1:0]        route_rresp   [2];

    assign m_awvalid[0] = m0.awvalid;  assign m_awvalid[1] = m1.awvalid;
    assign m_awaddr[0]  = m0.awaddr;   assign m_awaddr[1]  = m1.awaddr;
    assign m_wvalid[0]  = m0.wvalid;   assign m_wvalid[1]  = m1.wvalid;
    assign m_wdata[0]   = m0.wdata;    assign m_wdata[1]   = m1.wdata;
    assign m_wstrb[0]   = m0.wstrb;    assign m_wstrb[1]   = m1.wstrb;
    assign m_bready[0]  = m0.bready;   assign m_bready[1]  = m1.bready;
    assign m_arvalid[0] = m0.arvalid;  assign m_arvalid[1] = m1.arvalid;
    assign m_araddr[0]  = m0.araddr;   assign m_araddr[1]  = m1.araddr;
    assign m_rready[0]  = m0.rready;   assign m_rready[1]  = m1.rready;

    assign wreq = {m_awvalid[1], m_awvalid[0]};
    assign rreq = {m_arvalid[1], m_arvalid[0]};

    rr_arbiter2 u_rr (
        .req         (wreq | rreq),
        .last        (last_reg),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_idx;
                    last_next  = grant_idx;
                    state_next = wreq[grant_idx] ? WR : RD;
                end
            end
            RD:      if (s.rvalid && m_rready[owner_reg]) state_next = IDLE;
            WR:      if (s.bvalid && m_bready[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Routing also depends on aresetn so a reset cuts the slave off before the edge
    logic rd_act;
    logic wr_act;
    assign rd_act = aresetn && (state_reg == RD);
    assign wr_act = aresetn && (state_reg == WR);

    assign s.awvalid = wr_act && m_awvalid[owner_reg];
    assign s.awaddr  = wr_act ? m_awaddr[owner_reg] : '0;
    assign s.wvalid  = wr_act && m_wvalid[owner_reg];
    assign s.wdata   = wr_act ? m_wdata[owner_reg] : '0;
    assign s.wstrb   = wr_act ? m_wstrb[owner_reg] : '0;
    assign s.bready  = wr_act && m_bready[owner_reg];
    assign s.arvalid = rd_act && m_arvalid[owner_reg];
    assign s.araddr  = rd_act ? m_araddr[owner_reg] : '0;
    assign s.rready  = rd_act && m_rready[owner_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            logic own_wr;
            logic own_rd;
            assign own_wr = wr_act && (owner_reg == 1'(gi));
            assign own_rd = rd_act && (owner_reg == 1'(gi));

            assign route_awready[gi] = own_wr && s.awready;
            assign route_wready[gi]  = own_wr && s.wready;
            assign route_bvalid[gi]  = own_wr && s.bvalid;
            assign route_bresp[gi]   = own_wr ? s.bresp : RESP_OKAY;
            assign route_arready[gi] = own_rd && s.arready;
            assign route_rvalid[gi]  = own_rd && s.rvalid;
            assign route_rdata[gi]   = own_rd ? s.rdata : '0;
            assign route_rresp[gi]   = own_rd ? s.rresp : RESP_OKAY;
        end
    endgenerate

    assign m0.awready = route_awready[0];  assign m1.awready = route_awready[1];
    assign m0.wready  = route_wready[0];   assign m1.wready  = route_wready[1];
    assign m0.bvalid  = route_bvalid[0];   assign m1.bvalid  = route_bvalid[1];
    assign m0.bresp   = route_bresp[0];    assign m1.bresp   = route_bresp[1];
    assign m0.arready = route_arready[0];  assign m1.arready = route_arready[1];
    assign m0.rvalid  = route_rvalid[0];   assign m1.rvalid  = route_rvalid[1];
    assign m0.rdata   = route_rdata[0];    assign m1.rdata   = route_rdata[1];
    assign m0.rresp   = route_rresp[0];    assign m1.rresp   = route_rresp[1];

endmodule

// File: tb/tb_axi4lite_arbiter2.sv
// Directed bench for axi4lite_arbiter2: simple reactive master/slave models stepped once per clock.
module tb_axi4lite_arbiter2;
    import axi4lite_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4lite_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) m0_bus ();
    axi4lite_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) m1_bus ();
    axi4lite_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) s_bus ();

    axi4lite_arbiter2 #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] rd_data_cfg;
    int          rd_left [2];
    int          r_cnt   [2];
    int          b_cnt   [2];
    logic [31:0] r_last_data [2];
    logic [1:0]  r_last_resp [2];
    logic [1:0]  b_last_resp [2];
    logic        s_got_aw, s_got_w;
    logic [31:0] s_ar_log [$];
    logic [31:0] s_aw_log [$];
    logic [31:0] s_wdata_last;
    logic [7:0]  s_wstrb_last;
    int          gnt_owner [$];
    int          gnt_kind  [$];
    logic        watch_m1;
    int          leak_m1;

    // One clock: sample handshakes at negedge, update models just after posedge
    task automatic tick();
        logic ar0, ar1, r0, r1, aw0, aw1, w0, w1, b0, b1;
        logic s_ar, s_r, s_aw, s_w, s_b;
        logic was_idle;
        @(negedge aclk);
        ar0 = m0_bus.arvalid & m0_bus.arready;  ar1 = m1_bus.arvalid & m1_bus.arready;
        r0  = m0_bus.rvalid  & m0_bus.rready;   r1  = m1_bus.rvalid  & m1_bus.rready;
        aw0 = m0_bus.awvalid & m0_bus.awready;  aw1 = m1_bus.awvalid & m1_bus.awready;
        w0  = m0_bus.wvalid  & m0_bus.wready;   w1  = m1_bus.wvalid  & m1_bus.wready;
        b0  = m0_bus.bvalid  & m0_bus.bready;   b1  = m1_bus.bvalid  & m1_bus.bready;
        s_ar = s_bus.arvalid & s_bus.arready;
        s_r  = s_bus.rvalid  & s_bus.rready;
        s_aw = s_bus.awvalid & s_bus.awready;
        s_w  = s_bus.wvalid  & s_bus.wready;
        s_b  = s_bus.bvalid  & s_bus.bready;
        if (watch_m1 && (m1_bus.awready || m1_bus.wready || m1_bus.bvalid || m1_bus.arready ||
                         m1_bus.rvalid || (|m1_bus.rdata) || (|m1_bus.rresp) || (|m1_bus.bresp)))
            leak_m1++;
        if (s_ar) s_ar_log.push_back(s_bus.araddr);
        if (s_aw) s_aw_log.push_back(s_bus.awaddr);
        if (s_w) begin s_wdata_last = s_bus.wdata; s_wstrb_last = s_bus.wstrb; end
        if (r0) begin r_last_data[0] = m0_bus.rdata; r_last_resp[0] = m0_bus.rresp; end
        if (r1) begin r_last_data[1] = m1_bus.rdata; r_last_resp[1] = m1_bus.rresp; end
        if (b0) b_last_resp[0] = m0_bus.bresp;
        if (b1) b_last_resp[1] = m1_bus.bresp;
        was_idle = (dut.state_reg == IDLE);
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            s_bus.rvalid = 1'b0;
            s_bus.bvalid = 1'b0;
            s_got_aw = 1'b0;
            s_got_w  = 1'b0;
        end else begin
            if (s_r) s_bus.rvalid = 1'b0;
            if (s_ar) begin s_bus.rvalid = 1'b1; s_bus.rdata = rd_data_cfg; s_bus.rresp = RESP_OKAY; end
            if (s_b) begin s_bus.bvalid = 1'b0; s_got_aw = 1'b0; s_got_w = 1'b0; end
            if (s_aw) s_got_aw = 1'b1;
            if (s_w)  s_got_w  = 1'b1;
            if (s_got_aw && s_got_w && !s_bus.bvalid && !s_b) begin
                s_bus.bvalid = 1'b1;
                s_bus.bresp  = RESP_OKAY;
            end
        end
        if (ar0) m0_bus.arvalid = 1'b0;
        if (aw0) m0_bus.awvalid = 1'b0;
        if (w0)  m0_bus.wvalid  = 1'b0;
        if (b0)  b_cnt[0]++;
        if (r0) begin r_cnt[0]++; rd_left[0]--; if (rd_left[0] > 0) m0_bus.arvalid = 1'b1; end
        if (ar1) m1_bus.arvalid = 1'b0;
        if (aw1) m1_bus.awvalid = 1'b0;
        if (w1)  m1_bus.wvalid  = 1'b0;
        if (b1)  b_cnt[1]++;
        if (r1) begin r_cnt[1]++; rd_left[1]--; if (rd_left[1] > 0) m1_bus.arvalid = 1'b1; end
        if (was_idle && dut.state_reg != IDLE) begin
            gnt_owner.push_back(int'(dut.owner_reg));
            gnt_kind.push_back(int'(dut.state_reg));
        end
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            r_cnt[i] = 0; b_cnt[i] = 0; rd_left[i] = 0;
            r_last_data[i] = '0; r_last_resp[i] = 2'b11; b_last_resp[i] = 2'b11;
        end
        s_ar_log.delete(); s_aw_log.delete(); gnt_owner.delete(); gnt_kind.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m0_bus.awvalid = 0; m0_bus.wvalid = 0; m0_bus.arvalid = 0;
        m1_bus.awvalid = 0; m1_bus.wvalid = 0; m1_bus.arvalid = 0;
        tick(); tick();
        aresetn = 1'b1;
        clear_logs();
    endtask

    initial begin
        m0_bus.awvalid = 0; m0_bus.awaddr = '0; m0_bus.wvalid = 0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m0_bus.bready = 1; m0_bus.arvalid = 0; m0_bus.araddr = '0; m0_bus.rready = 1;
        m1_bus.awvalid = 0; m1_bus.awaddr = '0; m1_bus.wvalid = 0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        m1_bus.bready = 1; m1_bus.arvalid = 0; m1_bus.araddr = '0; m1_bus.rready = 1;
        s_bus.awready = 1; s_bus.wready = 1; s_bus.arready = 1;
        s_bus.bvalid = 0; s_bus.bresp = '0; s_bus.rvalid = 0; s_bus.rdata = '0; s_bus.rresp = '0;
        s_got_aw = 0; s_got_w = 0; s_wdata_last = '0; s_wstrb_last = '0;
        rd_data_cfg = '0; watch_m1 = 0; leak_m1 = 0;
        clear_logs();

        // Reset state, with a request present to prove it is gated
        m0_bus.arvalid = 1;
        tick(); tick();
        chk("rst_state", dut.state_reg, IDLE);
        chk("rst_owner", dut.owner_reg, 0);
        chk("rst_last", dut.last_reg, 1);
        chk("rst_s_arvalid", s_bus.arvalid, 0);
        chk("rst_m0_arready", m0_bus.arready, 0);
        chk("rst_m1_rvalid", m1_bus.rvalid, 0);
        m0_bus.arvalid = 0;
        aresetn = 1;
        tick();
        clear_logs();

        // Single read from m0
        watch_m1 = 1; leak_m1 = 0;
        rd_data_cfg = 32'hDEAD_BEEF;
        m0_bus.araddr = 32'h8000_0000; rd_left[0] = 1; m0_bus.arvalid = 1;
        #1;
        chk("rd_idle_no_comb", s_bus.arvalid, 0);
        tick();
        chk("rd_state", dut.state_reg, RD);
        chk("rd_s_arvalid", s_bus.arvalid, 1);
        chk("rd_s_araddr", s_bus.araddr, 32'h8000_0000);
        tick();
        chk("rd_m0_rvalid", m0_bus.rvalid, 1);
        chk("rd_m0_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
        chk("rd_m0_rresp", m0_bus.rresp, 2'b00);
        tick();
        chk("rd_back_idle", dut.state_reg, IDLE);
        chk("rd_count", r_cnt[0], 1);
        watch_m1 = 0;
        chk("rd_m1_quiet", leak_m1, 0);

        // Tie from reset: alternating grants
        do_reset();
        rd_data_cfg = 32'h0000_A5A5;
        m0_bus.araddr = 32'h100; m1_bus.araddr = 32'h200;
        rd_left[0] = 3; rd_left[1] = 3;
        m0_bus.arvalid = 1; m1_bus.arvalid = 1;
        for (int t = 0; t < 80 && !(r_cnt[0] == 3 && r_cnt[1] == 3); t++) tick();
        chk("tie_done", r_cnt[0] + r_cnt[1], 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tie_gnt%0d", i), (gnt_owner.size() > i) ? gnt_owner[i] : 99, i % 2);
            chk($sformatf("tie_addr%0d", i), (s_ar_log.size() > i) ? s_ar_log[i] : 32'hFFFF_FFFF,
                (i % 2) ? 32'h200 : 32'h100);
        end

        // Write wins over a read raised together by m1
        clear_logs();
        rd_data_cfg = 32'h0BAD_F00D;
        m1_bus.awaddr = 32'h3000; m1_bus.wdata = 32'h1234_5678; m1_bus.wstrb = 8'h0F;
        m1_bus.araddr = 32'h4000; rd_left[1] = 1;
        m1_bus.awvalid = 1; m1_bus.wvalid = 1; m1_bus.arvalid = 1;
        for (int t = 0; t < 40 && !(b_cnt[1] == 1 && r_cnt[1] == 1); t++) tick();
        chk("wor_kind0", (gnt_kind.size() > 0) ? gnt_kind[0] : 0, 64'(WR));
        chk("wor_kind1", (gnt_kind.size() > 1) ? gnt_kind[1] : 0, 64'(RD));
        chk("wor_owner1", (gnt_owner.size() > 1) ? gnt_owner[1] : 99, 1);
        chk("wor_awaddr", (s_aw_log.size() > 0) ? s_aw_log[0] : 0, 32'h3000);
        chk("wor_wdata", s_wdata_last, 32'h1234_5678);
        chk("wor_wstrb", s_wstrb_last, 8'h0F);
        chk("wor_bresp", b_last_resp[1], 2'b00);
        chk("wor_araddr", (s_ar_log.size() > 0) ? s_ar_log[0] : 0, 32'h4000);
        chk("wor_rdata", r_last_data[1], 32'h0BAD_F00D);

        // Backpressure on R from m0 while m1 waits
        clear_logs();
        m0_bus.rready = 0;
        m0_bus.araddr = 32'h500; m1_bus.araddr = 32'h600;
        rd_left[0] = 1; rd_left[1] = 1;
        m0_bus.arvalid = 1; m1_bus.arvalid = 1;
        tick();
        chk("bp_grant_owner", dut.owner_reg, 0);
        tick();
        chk("bp_rvalid", m0_bus.rvalid, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("bp_hold_state%0d", k), dut.state_reg, RD);
            chk($sformatf("bp_m1_blocked%0d", k), m1_bus.arready, 0);
        end
        m0_bus.rready = 1;
        tick();
        chk("bp_idle", dut.state_reg, IDLE);
        tick();
        chk("bp_m1_state", dut.state_reg, RD);
        chk("bp_m1_owner", dut.owner_reg, 1);
        for (int t = 0; t < 20 && r_cnt[1] != 1; t++) tick();
        chk("bp_m1_done", r_cnt[1], 1);

        // Reset asserted in the middle of a write
        clear_logs();
        m0_bus.bready = 0;
        m0_bus.awaddr = 32'h700; m0_bus.wdata = 32'hCAFE_F00D; m0_bus.wstrb = 8'hFF;
        m0_bus.awvalid = 1; m0_bus.wvalid = 1;
        tick();
        chk("rw_state", dut.state_reg, WR);
        tick();
        tick();
        chk("rw_bvalid", m0_bus.bvalid, 1);
        aresetn = 0;
        #1;
        chk("rw_gate_now", m0_bus.bvalid, 0);
        tick();
        chk("rw_state_idle", dut.state_reg, IDLE);
        chk("rw_last", dut.last_reg, 1);
        chk("rw_owner", dut.owner_reg, 0);
        chk("rw_outs", {m0_bus.bvalid, m0_bus.awready, m0_bus.wready, s_bus.awvalid, s_bus.bready}, 0);
        aresetn = 1;
        m0_bus.bready = 1;
        clear_logs();
        rd_data_cfg = 32'h5555_AAAA;
        m0_bus.araddr = 32'h800; rd_left[0] = 1; m0_bus.arvalid = 1;
        tick();
        chk("rw_regrant", dut.state_reg, RD);
        for (int t = 0; t < 20 && r_cnt[0] != 1; t++) tick();
        chk("rw_rdata", r_last_data[0], 32'h5555_AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_arbiter2.md
# axi4lite_arbiter2

Two-master to one-slave AXI4-lite arbiter for the NPC memory path: the instruction fetch unit (m0) and load/store unit (m1) share the single `axi4lite_uart_slave`/pmem slave. Whole transactions are granted round-robin. Channels of the owning master are routed combinationally to the slave until that transaction's response handshake completes. The non-owner is held off with all readies and valids low.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STRB_W`, default 8: write-strobe width; matches the shared slave.

Ports, with N = 0, 1:
- `aclk` in 1: clock.
- `aresetn` in 1: **reset is synchronous and active-low**; one clock domain only.
- `mN_aw*` (`awvalid` in, `awready` out, `awaddr` in ADDR_W): write-address channel from master N.
- `mN_w*` (`wvalid` in, `wready` out, `wdata` in DATA_W, `wstrb` in STRB_W): write-data channel from master N.
- `mN_b*` (`bvalid` out, `bready` in, `bresp` out 2): write-response channel to master N.
- `mN_ar*` (`arvalid` in, `arready` out, `araddr` in ADDR_W): read-address channel from master N.
- `mN_r*` (`rvalid` out, `rready` in, `rdata` out DATA_W, `rresp` out 2): read-data channel to master N.
- `s_aw*`, `s_w*`, `s_b*`, `s_ar*`, `s_r*`: the same channel set toward the slave, with directions mirrored.

## Operation
- FSM states:
  - IDLE: no owner; all `mN_*ready`, `mN_*valid`, and `s_*valid` are 0; `s_bready`/`s_rready` are 0.
  - RD: a read is in flight for `owner`.
  - WR: a write is in flight for `owner`.
- Request per master: `wreq_N = mN_awvalid`, `rreq_N = mN_arvalid`, `req_N = wreq_N | rreq_N`.
- Arbitration happens in IDLE only.
  - If exactly one `req_N` is set, grant N.
  - If both are set, grant the master that is not `last`.
  - On grant, `owner <= N` and `last <= N`.
  - The next state is WR if `wreq_N` is set, otherwise RD. A write wins when one master raises both AR and AW.
- RD routing:
  - `s_ar*` is driven from `m<owner>_ar*`, and `m<owner>_arready = s_arready`.
  - `m<owner>_r*` is driven from `s_r*`, and `s_rready = m<owner>_rready`.
  - The AW/W/B channels are gated to 0 on both sides.
- WR routing:
  - AW, W and B are routed the same way as in RD.
  - The AR/R channels are gated to 0.
  - AW and W may handshake in either order or in the same cycle.
- Completion:
  - RD returns to IDLE after the cycle with `s_rvalid & m<owner>_rready`.
  - WR returns to IDLE after the cycle with `s_bvalid & m<owner>_bready`.
- Non-owner: every output is 0 and its requests are ignored; it holds its valids per AXI rules.
- Gated data/resp outputs read as 0, never X.
- Reset values: state IDLE, `owner = 0`, `last = 1` so that m0 wins the first tie, and every output 0.
- Reset asserted mid-transaction: the FSM goes to IDLE on the next edge. The in-flight transaction is abandoned without a response, and the slave's outputs are gated off immediately.

## Timing
- Grant latency: a request seen in IDLE at cycle T causes the slave-side valid to appear at T+1. There is no combinational path from `mN_*valid` to `s_*valid` while in IDLE.
- Response path: owner R/B channels are combinational pass-through with zero added cycles. Ready and valid signals are never registered inside the arbiter.
- Back-to-back:
  - Completion at cycle C gives IDLE at C+1 and the next grant's valid at C+2.
  - Minimum inter-transaction gap is one IDLE cycle.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, … Worst-case wait is one transaction.
- Owner switching: the owner changes only on an IDLE to RD/WR transition; no change occurs mid-transaction.

## Structure
- Shared package `axi4lite_pkg`:
  - response codes `RESP_OKAY = 2'b00`, `RESP_SLVERR = 2'b10`;
  - FSM state enum `arb_state_t` {IDLE, RD, WR};
  - default widths.
- Sub-module `rr_arbiter2`:
  - inputs: `req[1:0]`, `last`;
  - outputs: `grant_idx`, `grant_valid`;
  - purely combinational pick, reused later for DMA sharing.
- The top level holds the FSM, the `owner`/`last` registers, and the channel muxes and gating.

## Test plan
- **Single read:** m0 `arvalid`, `araddr = 0x8000_0000`, slave returns `rdata = 0xDEAD_BEEF` → m0 sees `rvalid` with that data and `rresp = 00`; m1 outputs stay 0 throughout; the FSM is in IDLE the cycle after the R handshake.
- **Tie:** m0 and m1 both `arvalid` from reset → m0 is granted first and m1 second; with both held continuously for 6 transactions, the grant order is 0, 1, 0, 1, 0, 1.
- **Write-over-read:** m1 raises AW, W (`wdata = 0x1234_5678`, `wstrb = 0x0F`) and AR together → WR is granted first; the slave sees the write and then m1's read in a later transaction; `bresp = 00`.
- **Backpressure:** the owner holds `rready = 0` for 4 cycles after `s_rvalid` → the FSM stays in RD; the non-owner request is not granted until the cycle after `rready` rises.
- **Reset mid-write:** `aresetn` is pulled low while in WR before the B handshake → next edge: IDLE, all outputs 0, `last = 1`; after reset is released, a new m0 request is granted normally.
